// File: rtl/stream_demux_n.sv
// stream_demux_n: registered 1:N valid/ready stream demultiplexer.
// Whole packets are routed to one output lane, chosen either by an explicit
// select (addressed mode) or by a rotating pointer (round-robin mode).
// Each lane owns a one-entry output register. Beats addressed to a
// non-existent lane are accepted, discarded and counted.
module stream_demux_n #(
    parameter int WIDTH = 8,
    parameter int N_OUT = 4,
    parameter int SEL_W = $clog2(N_OUT),
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mode,
    input  logic [SEL_W-1:0]       sel,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_valid,
    input  logic                   in_last,
    output logic                   in_ready,
    output logic [N_OUT*WIDTH-1:0] out_data,
    output logic [N_OUT-1:0]       out_valid,
    output logic [N_OUT-1:0]       out_last,
    input  logic [N_OUT-1:0]       out_ready,
    output logic                   busy,
    output logic [CNT_W-1:0]       drop_count
);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    // Lanes are numbered 0..N_OUT-1; anything at or above N_LIM is a drop.
    localparam logic [SEL_W:0]   N_LIM   = (SEL_W+1)'(N_OUT);
    localparam logic [SEL_W-1:0] RR_LAST = SEL_W'(N_OUT - 1);

    state_t           state;
    state_t           state_next;
    logic [SEL_W-1:0] lock_ch;
    logic             lock_mode;
    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] tgt;
    logic [SEL_W-1:0] tgt_idx;
    logic             pkt_mode;
    logic             drop_beat;
    logic             transfer;

    // Pick the destination lane: fresh decision in IDLE, latched lane while a packet is open.
    always_comb begin
        tgt      = lock_ch;
        pkt_mode = lock_mode;
        if (state == IDLE) begin
            pkt_mode = mode;
            tgt      = mode ? rr_ptr : sel;
        end
        drop_beat = ({1'b0, tgt} >= N_LIM);
        tgt_idx   = drop_beat ? '0 : tgt;
        in_ready  = rst ? 1'b0
                        : (drop_beat | ~out_valid[tgt_idx] | out_ready[tgt_idx]);
        transfer  = in_valid & in_ready;
    end

    // Next-state logic: a packet stays locked until its last beat transfers.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (transfer && !in_last) state_next = LOCKED;
            LOCKED:  if (transfer && in_last)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register plus the lane and mode captured on a packet's first beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            lock_ch   <= '0;
            lock_mode <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && transfer) begin
                lock_ch   <= tgt;
                lock_mode <= mode;
            end
        end
    end

    // Round-robin pointer moves on the closing beat of a round-robin packet only.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (transfer && in_last && pkt_mode) begin
            rr_ptr <= (rr_ptr == RR_LAST) ? '0 : rr_ptr + SEL_W'(1);
        end
    end

    // Per-lane output registers: a new load wins over a same-cycle consume.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= '0;
            out_last  <= '0;
            out_data  <= '0;
        end else begin
            for (int k = 0; k < N_OUT; k++) begin
                if (transfer && !drop_beat && tgt == SEL_W'(k)) begin
                    out_data[k*WIDTH +: WIDTH] <= in_data;
                    out_last[k]                <= in_last;
                    out_valid[k]               <= 1'b1;
                end else if (out_ready[k]) begin
                    out_valid[k] <= 1'b0;
                end
            end
        end
    end

    // Saturating count of beats discarded for an out-of-range lane.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_count <= '0;
        end else if (transfer && drop_beat && drop_count != '1) begin
            drop_count <= drop_count + CNT_W'(1);
        end
    end

    assign busy = (state == LOCKED);

endmodule
